// File: rtl/shift_arbiter.sv
// Shares one 32-bit SLL/SRL/SRA shifter between two requesters through a single registered result stage.
// A request transfers on an edge where REQ_x_VALID & REQ_x_RDY; a response transfers where RSP_x_VALID & RSP_x_RDY.
module shift_arbiter #(
    parameter bit RR_EN   = 1'b1,
    parameter int SHIFT_W = 32
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       REQ_A_VALID,
    input  logic [SHIFT_W-1:0]         REQ_A_D,
    input  logic [$clog2(SHIFT_W)-1:0] REQ_A_SHAMT,
    input  logic [1:0]                 REQ_A_OP,
    output logic                       REQ_A_RDY,
    output logic                       RSP_A_VALID,
    output logic [SHIFT_W-1:0]         RSP_A_RES,
    input  logic                       RSP_A_RDY,
    input  logic                       REQ_B_VALID,
    input  logic [SHIFT_W-1:0]         REQ_B_D,
    input  logic [$clog2(SHIFT_W)-1:0] REQ_B_SHAMT,
    input  logic [1:0]                 REQ_B_OP,
    output logic                       REQ_B_RDY,
    output logic                       RSP_B_VALID,
    output logic [SHIFT_W-1:0]         RSP_B_RES,
    input  logic                       RSP_B_RDY,
    output logic                       BUSY,
    output logic [1:0]                 dbg_state
);

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] FULL_A = 2'd1;
    localparam logic [1:0] FULL_B = 2'd2;
    localparam logic       GNT_A  = 1'b0;
    localparam logic       GNT_B  = 1'b1;

    logic [1:0]         state_q, state_d;
    logic               last_gnt_q, last_gnt_d;
    logic [SHIFT_W-1:0] res_q, res_d;
    logic               full_a, full_b, drain, can_accept, gnt_b;

    // op = {RIGHT, ARITH}; 01 falls into the left-shift default
    function automatic logic [SHIFT_W-1:0] do_shift(
        input logic [SHIFT_W-1:0]         d,
        input logic [$clog2(SHIFT_W)-1:0] s,
        input logic [1:0]                 op
    );
        logic [SHIFT_W-1:0] r;
        case (op)
            2'b10:   r = d >> s;
            2'b11:   r = $unsigned($signed(d) >>> s);
            default: r = d << s;
        endcase
        return r;
    endfunction

    assign full_a      = (state_q == FULL_A);
    assign full_b      = (state_q == FULL_B);
    assign RSP_A_VALID = full_a;
    assign RSP_B_VALID = full_b;
    assign RSP_A_RES   = res_q;
    assign RSP_B_RES   = res_q;
    assign BUSY        = (state_q != EMPTY);
    assign dbg_state   = state_q;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        res_d      = res_q;
        drain      = (full_a & RSP_A_RDY) | (full_b & RSP_B_RDY);
        can_accept = (state_q == EMPTY) | drain;
        // B wins only when alone, or on a tie under round-robin after A went last
        gnt_b      = REQ_B_VALID & (~REQ_A_VALID | (RR_EN & (last_gnt_q == GNT_A)));
        REQ_A_RDY  = ~RST & can_accept & REQ_A_VALID & ~gnt_b;
        REQ_B_RDY  = ~RST & can_accept & REQ_B_VALID & gnt_b;
        if (REQ_A_RDY) begin
            res_d      = do_shift(REQ_A_D, REQ_A_SHAMT, REQ_A_OP);
            last_gnt_d = GNT_A;
            state_d    = FULL_A;
        end else if (REQ_B_RDY) begin
            res_d      = do_shift(REQ_B_D, REQ_B_SHAMT, REQ_B_OP);
            last_gnt_d = GNT_B;
            state_d    = FULL_B;
        end else if (drain) begin
            state_d    = EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= EMPTY;
            last_gnt_q <= GNT_B;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            res_q      <= res_d;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed steps plus a random sweep, with a queue-based model of the
// round-robin instance checked on every falling edge.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a_valid, req_b_valid, rsp_a_rdy, rsp_b_rdy;
    logic [31:0] req_a_d, req_b_d;
    logic [4:0]  req_a_shamt, req_b_shamt;
    logic [1:0]  req_a_op, req_b_op;

    logic        rr_req_a_rdy, rr_req_b_rdy, rr_rsp_a_valid, rr_rsp_b_valid, rr_busy;
    logic [31:0] rr_rsp_a_res, rr_rsp_b_res;
    logic [1:0]  rr_dbg_state;
    logic        fp_req_a_rdy, fp_req_b_rdy, fp_rsp_a_valid, fp_rsp_b_valid, fp_busy;
    logic [31:0] fp_rsp_a_res, fp_rsp_b_res;
    logic [1:0]  fp_dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    logic        mon_en = 1'b0;
    logic        m_last_b, m_full_a, m_full_b, m_can, m_gb, m_ea, m_eb;
    logic        hs_a, hs_b;
    logic [31:0] cap_d;
    logic [4:0]  cap_s;
    logic [1:0]  cap_op;

    always #5 clk = ~clk;

    shift_arbiter #(.RR_EN(1'b1), .SHIFT_W(32)) dut_rr (
        .CLK(clk), .RST(rst),
        .REQ_A_VALID(req_a_valid), .REQ_A_D(req_a_d), .REQ_A_SHAMT(req_a_shamt), .REQ_A_OP(req_a_op),
        .REQ_A_RDY(rr_req_a_rdy), .RSP_A_VALID(rr_rsp_a_valid), .RSP_A_RES(rr_rsp_a_res), .RSP_A_RDY(rsp_a_rdy),
        .REQ_B_VALID(req_b_valid), .REQ_B_D(req_b_d), .REQ_B_SHAMT(req_b_shamt), .REQ_B_OP(req_b_op),
        .REQ_B_RDY(rr_req_b_rdy), .RSP_B_VALID(rr_rsp_b_valid), .RSP_B_RES(rr_rsp_b_res), .RSP_B_RDY(rsp_b_rdy),
        .BUSY(rr_busy), .dbg_state(rr_dbg_state)
    );

    shift_arbiter #(.RR_EN(1'b0), .SHIFT_W(32)) dut_fp (
        .CLK(clk), .RST(rst),
        .REQ_A_VALID(req_a_valid), .REQ_A_D(req_a_d), .REQ_A_SHAMT(req_a_shamt), .REQ_A_OP(req_a_op),
        .REQ_A_RDY(fp_req_a_rdy), .RSP_A_VALID(fp_rsp_a_valid), .RSP_A_RES(fp_rsp_a_res), .RSP_A_RDY(rsp_a_rdy),
        .REQ_B_VALID(req_b_valid), .REQ_B_D(req_b_d), .REQ_B_SHAMT(req_b_shamt), .REQ_B_OP(req_b_op),
        .REQ_B_RDY(fp_req_b_rdy), .RSP_B_VALID(fp_rsp_b_valid), .RSP_B_RES(fp_rsp_b_res), .RSP_B_RDY(rsp_b_rdy),
        .BUSY(fp_busy), .dbg_state(fp_dbg_state)
    );

    // Shifts expressed as multiply/divide by 2**s; SRA is floor division, i.e. ~(~d / 2**s) for negatives
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        logic [63:0] scale;
        logic [63:0] prod;
        scale = 64'd1;
        for (int i = 0; i < int'(s); i++) scale = scale * 64'd2;
        prod = {32'd0, d} * scale;
        case (op)
            2'b10:   return 32'({32'd0, d} / scale);
            2'b11:   return d[31] ? ~(32'({32'd0, ~d} / scale)) : 32'({32'd0, d} / scale);
            default: return prod[31:0];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rand_shamt();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic rand_a();
        req_a_d = $urandom; req_a_shamt = rand_shamt(); req_a_op = 2'($urandom_range(0, 3));
    endtask

    task automatic rand_b();
        req_b_d = $urandom; req_b_shamt = rand_shamt(); req_b_op = 2'($urandom_range(0, 3));
    endtask

    // Model of the round-robin instance: a port's queue is non-empty exactly while it owns the result register
    always @(negedge clk) begin
        if (mon_en) begin
            m_full_a = (exp_a_q.size() != 0);
            m_full_b = (exp_b_q.size() != 0);
            m_can = (!m_full_a && !m_full_b) || (m_full_a && rsp_a_rdy) || (m_full_b && rsp_b_rdy);
            m_gb  = req_b_valid && (!req_a_valid || !m_last_b);
            m_ea  = !rst && m_can && req_a_valid && !m_gb;
            m_eb  = !rst && m_can && req_b_valid && m_gb;
            check("mon_req_a_rdy", 32'(rr_req_a_rdy), 32'(m_ea));
            check("mon_req_b_rdy", 32'(rr_req_b_rdy), 32'(m_eb));
            check("mon_rsp_a_valid", 32'(rr_rsp_a_valid), 32'(m_full_a));
            check("mon_rsp_b_valid", 32'(rr_rsp_b_valid), 32'(m_full_b));
            check("mon_busy", 32'(rr_busy), 32'(m_full_a || m_full_b));
            if (m_full_a) check("mon_rsp_a_res", rr_rsp_a_res, exp_a_q[0]);
            if (m_full_b) check("mon_rsp_b_res", rr_rsp_b_res, exp_b_q[0]);
            if (rst) begin
                exp_a_q.delete();
                exp_b_q.delete();
                m_last_b = 1'b1;
            end else begin
                if (m_full_a && rsp_a_rdy) void'(exp_a_q.pop_front());
                if (m_full_b && rsp_b_rdy) void'(exp_b_q.pop_front());
                if (m_ea) begin
                    exp_a_q.push_back(ref_shift(req_a_d, req_a_shamt, req_a_op));
                    m_last_b = 1'b0;
                end
                if (m_eb) begin
                    exp_b_q.push_back(ref_shift(req_b_d, req_b_shamt, req_b_op));
                    m_last_b = 1'b1;
                end
            end
        end
    end

    initial begin
        logic exp_b;
        rst = 1'b1;
        req_a_valid = 1'b0; req_b_valid = 1'b0;
        req_a_d = '0; req_a_shamt = '0; req_a_op = '0;
        req_b_d = '0; req_b_shamt = '0; req_b_op = '0;
        rsp_a_rdy = 1'b1; rsp_b_rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_last_b = 1'b1;
        mon_en = 1'b1;

        // Reset state
        check("rst_busy", 32'(rr_busy), 32'd0);
        check("rst_rsp_a_valid", 32'(rr_rsp_a_valid), 32'd0);
        check("rst_rsp_b_valid", 32'(rr_rsp_b_valid), 32'd0);
        check("rst_req_a_rdy", 32'(rr_req_a_rdy), 32'd0);
        check("rst_fp_busy", 32'(fp_busy), 32'd0);

        // 1: single SRA on A
        req_a_valid = 1'b1; req_a_d = 32'h8000_00F0; req_a_shamt = 5'd4; req_a_op = 2'b11;
        #1 check("t1_req_a_rdy", 32'(rr_req_a_rdy), 32'd1);
        tick();
        req_a_valid = 1'b0;
        check("t1_rsp_a_valid", 32'(rr_rsp_a_valid), 32'd1);
        check("t1_rsp_a_res", rr_rsp_a_res, 32'hF800_000F);
        tick();
        check("t1_drained", 32'(rr_busy), 32'd0);

        // 2: both ports always valid, round-robin alternates starting with B (A went last)
        rand_a(); rand_b();
        req_a_valid = 1'b1; req_b_valid = 1'b1;
        exp_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t2_gnt_b", 32'(rr_req_b_rdy), 32'(exp_b));
            check("t2_gnt_a", 32'(rr_req_a_rdy), 32'(!exp_b));
            tick();
            check("t2_no_bubble", 32'(rr_busy), 32'd1);
            check("t2_rsp_b_owner", 32'(rr_rsp_b_valid), 32'(exp_b));
            if (exp_b) rand_b(); else rand_a();
            exp_b = !exp_b;
        end
        req_a_valid = 1'b0; req_b_valid = 1'b0;
        tick();
        tick();

        // 3: B shift to the top bit, then backpressure for three cycles
        req_b_valid = 1'b1; req_b_d = 32'h0000_0001; req_b_shamt = 5'd31; req_b_op = 2'b00;
        #1 check("t3_req_b_rdy", 32'(rr_req_b_rdy), 32'd1);
        tick();
        req_b_valid = 1'b0; rsp_b_rdy = 1'b0; rsp_a_rdy = 1'b1;
        req_a_valid = 1'b1; req_a_d = 32'hF0F0_1234; req_a_shamt = 5'd0; req_a_op = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_hold_valid", 32'(rr_rsp_b_valid), 32'd1);
            check("t3_hold_res", rr_rsp_b_res, 32'h8000_0000);
            check("t3_hold_busy", 32'(rr_busy), 32'd1);
            check("t3_hold_a_rdy", 32'(rr_req_a_rdy), 32'd0);
            tick();
        end
        rsp_b_rdy = 1'b1;
        #1 check("t3_drain_accept", 32'(rr_req_a_rdy), 32'd1);
        tick();
        req_a_valid = 1'b0;
        check("t3_full_a_direct", 32'(rr_rsp_a_valid), 32'd1);
        check("t3_shamt0_res", rr_rsp_a_res, 32'hF0F0_1234);
        tick();
        tick();

        // 4: fixed-priority instance, A always wins a tie
        rand_a(); rand_b();
        req_a_valid = 1'b1; req_b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4_fp_gnt_a", 32'(fp_req_a_rdy), 32'd1);
            check("t4_fp_no_b", 32'(fp_req_b_rdy), 32'd0);
            cap_d = req_a_d; cap_s = req_a_shamt; cap_op = req_a_op;
            tick();
            check("t4_fp_rsp_a", 32'(fp_rsp_a_valid), 32'd1);
            check("t4_fp_res_a", fp_rsp_a_res, ref_shift(cap_d, cap_s, cap_op));
            rand_a();
        end
        req_a_valid = 1'b0;
        #1 check("t4_fp_gnt_b", 32'(fp_req_b_rdy), 32'd1);
        cap_d = req_b_d; cap_s = req_b_shamt; cap_op = req_b_op;
        tick();
        req_b_valid = 1'b0;
        check("t4_fp_rsp_b", 32'(fp_rsp_b_valid), 32'd1);
        check("t4_fp_res_b", fp_rsp_b_res, ref_shift(cap_d, cap_s, cap_op));
        tick();
        tick();

        // 5: reset while A's result is held
        rsp_a_rdy = 1'b0;
        req_a_valid = 1'b1; rand_a();
        #1 check("t5_req_a_rdy", 32'(rr_req_a_rdy), 32'd1);
        tick();
        req_a_valid = 1'b0;
        check("t5_held", 32'(rr_rsp_a_valid), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_valid", 32'(rr_rsp_a_valid), 32'd0);
        check("t5_rst_busy", 32'(rr_busy), 32'd0);
        rsp_a_rdy = 1'b1;
        rand_a(); rand_b();
        req_a_valid = 1'b1; req_b_valid = 1'b1;
        #1;
        check("t5_first_a", 32'(rr_req_a_rdy), 32'd1);
        check("t5_first_not_b", 32'(rr_req_b_rdy), 32'd0);
        tick();
        req_a_valid = 1'b0;
        tick();
        req_b_valid = 1'b0;
        tick();
        tick();

        // 6: random sweep; operands only change after a handshake or an early drop
        hs_a = 1'b0; hs_b = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!req_a_valid || hs_a) begin
                req_a_valid = 1'($urandom_range(0, 1)); rand_a();
            end else if ($urandom_range(0, 15) == 0) begin
                req_a_valid = 1'b0;
            end
            if (!req_b_valid || hs_b) begin
                req_b_valid = 1'($urandom_range(0, 1)); rand_b();
            end else if ($urandom_range(0, 15) == 0) begin
                req_b_valid = 1'b0;
            end
            rsp_a_rdy = ($urandom_range(0, 3) != 0);
            rsp_b_rdy = ($urandom_range(0, 3) != 0);
            #1;
            hs_a = req_a_valid && rr_req_a_rdy;
            hs_b = req_b_valid && rr_req_b_rdy;
            tick();
        end
        req_a_valid = 1'b0; req_b_valid = 1'b0;
        rsp_a_rdy = 1'b1; rsp_b_rdy = 1'b1;
        tick();
        tick();
        tick();
        check("t6_a_all_delivered", 32'(exp_a_q.size()), 32'd0);
        check("t6_b_all_delivered", 32'(exp_b_q.size()), 32'd0);
        check("t6_idle", 32'(rr_busy), 32'd0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
